// File: rtl/mips_instruction_category_stage.sv
// Multi-lane MIPS instruction categoriser: registered decode behind a
// 2-entry skid buffer, plus saturating per-category retirement counters.
module mips_instruction_category_stage #(
  parameter int LANES       = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [LANES*32-1:0]    inInstr,
  input  logic [LANES-1:0]       inLaneValid,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [LANES*32-1:0]    outInstr,
  output logic [LANES-1:0]       outLaneValid,
  output logic [LANES*14-1:0]    outCategory,
  input  logic                   countClear,
  input  logic [3:0]             countSel,
  output logic [COUNT_WIDTH-1:0] countValue
);

  localparam int NCAT = 14;
  localparam int IW   = LANES * 32;
  localparam int CWD  = LANES * NCAT;
  localparam int SW   = COUNT_WIDTH + 4;

  localparam logic [SW-1:0] SAT = {4'b0, {COUNT_WIDTH{1'b1}}};

  function automatic logic [13:0] decode(
    input logic [31:0] ins
  );
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rt4;
    logic        r;
    logic [13:0] c;
    op  = ins[31:26];
    fn  = ins[5:0];
    rt4 = ins[20];
    r   = (op == 6'b000000);
    c   = '0;
    c[0]  = r;
    c[1]  = !r;
    c[2]  = (r && fn[5:3] == 3'b001)
         || (!r && op[5:1] == 5'b00001);
    c[3]  = (op == 6'b000001)
         || (op[5:2] == 4'b0001);
    c[4]  = (op == 6'b000011)
         || (r && fn == 6'b001001)
         || (op == 6'b000001 && rt4);
    c[5]  = r && fn[5:3] == 3'b000;
    c[6]  = r && fn[5:2] == 4'b0001;
    c[7]  = r && fn[5:3] == 3'b010;
    c[8]  = r && fn[5:3] == 3'b011;
    c[9]  = (r && fn[5:3] == 3'b101)
         || (op[5:1] == 5'b00101);
    c[10] = (r && fn[5:2] == 4'b1001)
         || (op[5:2] == 4'b0011);
    c[11] = (r && fn[5:2] == 4'b1000)
         || (op[5:1] == 5'b00100);
    c[12] = op[5:3] == 3'b100;
    c[13] = op[5:3] == 3'b101;
    return c;
  endfunction

  logic           main_vld_q, main_vld_d;
  logic [IW-1:0]  main_ins_q, main_ins_d;
  logic [LANES-1:0] main_lv_q, main_lv_d;
  logic [CWD-1:0] main_cat_q, main_cat_d;

  logic           skid_vld_q, skid_vld_d;
  logic [IW-1:0]  skid_ins_q, skid_ins_d;
  logic [LANES-1:0] skid_lv_q, skid_lv_d;
  logic [CWD-1:0] skid_cat_q, skid_cat_d;

  logic [COUNT_WIDTH-1:0] cnt_q [NCAT];
  logic [COUNT_WIDTH-1:0] cnt_d [NCAT];
  logic [COUNT_WIDTH-1:0] cv_q, cv_d;

  logic [CWD-1:0] in_cat;
  logic           in_fire;
  logic           out_fire;
  logic [3:0]     inc [NCAT];
  logic [SW-1:0]  sum;

  assign inReady      = !skid_vld_q;
  assign outValid     = main_vld_q;
  assign outInstr     = main_ins_q;
  assign outLaneValid = main_lv_q;
  assign outCategory  = main_cat_q;
  assign countValue   = cv_q;

  assign in_fire  = inValid && !skid_vld_q;
  assign out_fire = main_vld_q && outReady;

  always_comb begin
    in_cat = '0;
    for (int i = 0; i < LANES; i++) begin
      in_cat[14*i +: 14] = decode(inInstr[32*i +: 32]);
    end
  end

  // Main refills when it drains or is empty; skid catches one beat of stall.
  always_comb begin
    main_vld_d = main_vld_q;
    main_ins_d = main_ins_q;
    main_lv_d  = main_lv_q;
    main_cat_d = main_cat_q;
    skid_vld_d = skid_vld_q;
    skid_ins_d = skid_ins_q;
    skid_lv_d  = skid_lv_q;
    skid_cat_d = skid_cat_q;
    if (out_fire || !main_vld_q) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_ins_d = skid_ins_q;
        main_lv_d  = skid_lv_q;
        main_cat_d = skid_cat_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_vld_d = 1'b1;
        main_ins_d = inInstr;
        main_lv_d  = inLaneValid;
        main_cat_d = in_cat;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_ins_d = inInstr;
      skid_lv_d  = inLaneValid;
      skid_cat_d = in_cat;
    end
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < NCAT; c++) begin
      inc[c] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (main_lv_q[i] && main_cat_q[14*i+c]) begin
          inc[c] = inc[c] + 4'd1;
        end
      end
    end
    for (int c = 0; c < NCAT; c++) begin
      sum = {4'b0, cnt_q[c]} + {{COUNT_WIDTH{1'b0}}, inc[c]};
      if (countClear) begin
        cnt_d[c] = '0;
      end else if (!out_fire) begin
        cnt_d[c] = cnt_q[c];
      end else if (sum > SAT) begin
        cnt_d[c] = {COUNT_WIDTH{1'b1}};
      end else begin
        cnt_d[c] = sum[COUNT_WIDTH-1:0];
      end
    end
  end

  // Read port samples the pre-update counter value.
  always_comb begin
    cv_d = '0;
    for (int c = 0; c < NCAT; c++) begin
      if (countSel == 4'(c)) begin
        cv_d = cnt_q[c];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      main_ins_q <= '0;
      main_lv_q  <= '0;
      main_cat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_ins_q <= '0;
      skid_lv_q  <= '0;
      skid_cat_q <= '0;
      cv_q       <= '0;
      for (int c = 0; c < NCAT; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      main_vld_q <= main_vld_d;
      main_ins_q <= main_ins_d;
      main_lv_q  <= main_lv_d;
      main_cat_q <= main_cat_d;
      skid_vld_q <= skid_vld_d;
      skid_ins_q <= skid_ins_d;
      skid_lv_q  <= skid_lv_d;
      skid_cat_q <= skid_cat_d;
      cv_q       <= cv_d;
      for (int c = 0; c < NCAT; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

endmodule

// File: tb/tb_mips_instruction_category_stage.sv
// Scoreboard bench for mips_instruction_category_stage: random and directed
// beats against a range-table category model and a counter model.
module tb_mips_instruction_category_stage;

  localparam int L   = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            inValid;
  logic            inReady;
  logic [L*32-1:0] inInstr;
  logic [L-1:0]    inLaneValid;
  logic            outValid;
  logic            outReady;
  logic [L*32-1:0] outInstr;
  logic [L-1:0]    outLaneValid;
  logic [L*14-1:0] outCategory;
  logic            countClear;
  logic [3:0]      countSel;
  logic [CW-1:0]   countValue;

  mips_instruction_category_stage #(
    .LANES(L),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clk),
    .reset(reset),
    .inValid(inValid),
    .inReady(inReady),
    .inInstr(inInstr),
    .inLaneValid(inLaneValid),
    .outValid(outValid),
    .outReady(outReady),
    .outInstr(outInstr),
    .outLaneValid(outLaneValid),
    .outCategory(outCategory),
    .countClear(countClear),
    .countSel(countSel),
    .countValue(countValue)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L*32-1:0] ins;
    logic [L-1:0]    lv;
    logic [L*14-1:0] cat;
  } beat_t;

  beat_t       sb[$];
  logic [13:0] seen[$];
  int          mcnt[14];
  int          pend_cv = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  bit          last_acc = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Category from opcode/function ranges, in decimal.
  function automatic logic [13:0] ref_cat(input logic [31:0] w);
    int op, fn, rt;
    logic [13:0] c;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    rt = int'(w[20:16]);
    c = '0;
    c[0] = (op == 0);
    c[1] = (op != 0);
    if (op == 0) begin
      c[5]  = (fn <= 7);
      c[6]  = (fn >= 4 && fn <= 7);
      c[2]  = (fn >= 8 && fn <= 15);
      c[4]  = (fn == 9);
      c[7]  = (fn >= 16 && fn <= 23);
      c[8]  = (fn >= 24 && fn <= 31);
      c[11] = (fn >= 32 && fn <= 35);
      c[10] = (fn >= 36 && fn <= 39);
      c[9]  = (fn >= 40 && fn <= 47);
    end else begin
      c[2]  = (op == 2 || op == 3);
      c[3]  = (op == 1 || (op >= 4 && op <= 7));
      c[4]  = (op == 3 || (op == 1 && rt >= 16));
      c[11] = (op == 8 || op == 9);
      c[9]  = (op == 10 || op == 11);
      c[10] = (op >= 12 && op <= 15);
      c[12] = (op >= 32 && op <= 39);
      c[13] = (op >= 40 && op <= 47);
    end
    return c;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0, 1: w[31:26] = 6'd0;
      2: w[31:26] = 6'($urandom_range(0, 15));
      default: ;
    endcase
    return w;
  endfunction

  // Input side: expected beat pushed when the handshake is seen.
  always @(negedge clk) begin
    #1;
    if (!reset && inValid && inReady) begin
      beat_t b;
      b.ins = inInstr;
      b.lv  = inLaneValid;
      b.cat = '0;
      for (int i = 0; i < L; i++) begin
        b.cat[14*i +: 14] = ref_cat(inInstr[32*i +: 32]);
      end
      sb.push_back(b);
      n_acc++;
    end
  end

  // Output side: occupancy, data, counters and read port.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int c = 0; c < 14; c++) mcnt[c] = 0;
      pend_cv = 0;
      chk("reset_state", {outValid, inReady, countValue},
          {1'b0, 1'b1, {CW{1'b0}}});
    end else begin
      chk("count_value", countValue, pend_cv);
      chk("out_valid", outValid, sb.size() > 0);
      chk("in_ready", inReady, sb.size() < 2);
      if (outValid && sb.size() == 0) begin
        chk("phantom_out", 1'b1, 1'b0);
      end
      if (outValid && sb.size() > 0) begin
        chk("out_instr", outInstr, sb[0].ins);
        chk("out_lane_valid", outLaneValid, sb[0].lv);
        chk("out_category", outCategory, sb[0].cat);
      end
      pend_cv = (countSel < 14) ? mcnt[countSel] : 0;
      if (outValid && outReady && sb.size() > 0) begin
        beat_t b;
        b = sb.pop_front();
        seen.push_back(outCategory[13:0]);
        for (int c = 0; c < 14; c++) begin
          for (int i = 0; i < L; i++) begin
            if (b.lv[i] && b.cat[14*i+c] && mcnt[c] < SAT) mcnt[c]++;
          end
        end
      end
      if (countClear) begin
        for (int c = 0; c < 14; c++) mcnt[c] = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    last_acc = inValid && inReady;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit want, input bit rdy);
    if (!inValid || last_acc) begin
      inValid = want;
      if (want) begin
        for (int i = 0; i < L; i++) inInstr[32*i +: 32] = rand_instr();
        inLaneValid = L'($urandom);
      end
    end
    outReady = rdy;
    step();
  endtask

  task automatic drive_beat(input logic [L*32-1:0] ins,
                            input logic [L-1:0] lv);
    bit done;
    done = 1'b0;
    inValid = 1'b1;
    inInstr = ins;
    inLaneValid = lv;
    for (int k = 0; k < 50; k++) begin
      if (!done) begin
        step();
        done = last_acc;
      end
    end
    inValid = 1'b0;
    if (!done) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!done) begin
        if (!inValid && !outValid) done = 1'b1;
        else cycle(1'b0, 1'b1);
      end
    end
    outReady = 1'b1;
    if (!done) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic clear_counters();
    countClear = 1'b1;
    step();
    countClear = 1'b0;
  endtask

  task automatic read_cnt(input logic [3:0] sel, output logic [CW-1:0] v);
    countSel = sel;
    step();
    v = countValue;
  endtask

  logic [31:0] dir_ins[4];
  logic [13:0] dir_cat[4];
  logic [CW-1:0] v;
  int base;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dir_ins = '{32'h00851020, 32'h8C820004, 32'h0C000010, 32'h04110002};
    dir_cat = '{14'h0801, 14'h1002, 14'h0016, 14'h001A};
    reset = 1'b1;
    inValid = 1'b0;
    inInstr = '0;
    inLaneValid = '0;
    outReady = 1'b1;
    countClear = 1'b0;
    countSel = 4'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed stream in lane 0
    base = seen.size();
    for (int k = 0; k < 4; k++) begin
      drive_beat({96'h0, dir_ins[k]}, 4'b0001);
    end
    drain();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dir_cat%0d", k), seen[base+k], dir_cat[k]);
    end

    // Backpressure: two beats absorbed, then stall
    base = n_acc;
    repeat (5) cycle(1'b1, 1'b0);
    chk("bp_accepted", n_acc - base, 2);
    chk("bp_in_ready", inReady, 1'b0);
    drain();

    // Four shifts, lanes 0, 1 and 3 occupied
    clear_counters();
    drive_beat({4{32'h00021080}}, 4'b1011);
    drain();
    read_cnt(4'd5, v);
    chk("shift_cnt", v, 3);
    read_cnt(4'd0, v);
    chk("register_cnt", v, 3);
    read_cnt(4'd6, v);
    chk("shiftv_cnt", v, 0);

    // Saturation at 2^CW-1
    clear_counters();
    repeat (20) drive_beat({96'h0, 32'h8C820004}, 4'b0001);
    drain();
    read_cnt(4'd12, v);
    chk("load_sat", v, SAT);

    // Clear wins over a same-edge increment
    clear_counters();
    drive_beat({96'h0, 32'h8C820004}, 4'b0001);
    countClear = 1'b1;
    step();
    countClear = 1'b0;
    read_cnt(4'd12, v);
    chk("clear_vs_inc", v, 0);

    // Out-of-range selector
    repeat (3) drive_beat({96'h0, 32'h8C820004}, 4'b0001);
    drain();
    read_cnt(4'd12, v);
    chk("load_three", v, 3);
    read_cnt(4'd15, v);
    chk("sel15", v, 0);

    // Reset with both entries full
    countSel = 4'd12;
    repeat (3) cycle(1'b1, 1'b0);
    chk("pre_reset_full", inReady, 1'b0);
    #2 reset = 1'b1;
    inValid = 1'b0;
    #1;
    chk("rst_out_valid", outValid, 1'b0);
    chk("rst_in_ready", inReady, 1'b1);
    chk("rst_count", countValue, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    last_acc = 1'b0;
    @(posedge clk);
    #1;
    repeat (5) cycle(1'b0, 1'b1);
    read_cnt(4'd12, v);
    chk("post_reset_cnt", v, 0);

    // Random traffic
    for (int k = 0; k < 2500; k++) begin
      countClear = ($urandom_range(0, 31) == 0);
      countSel = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    countClear = 1'b0;
    drain();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
